lumi_crdt: RTL
==============

# lumi_crdt

Credit-flow engine for one LUMI link, sitting directly downstream of the LUMI control registers.

- **Inputs:** the link enables, credit enable, credit-update interval and RX credit init values from the CSRs.
- **Transmit side:** gates the req/resp channels on remote credit and emits periodic credit-update messages advertising locally freed RX FIFO space.
- **Performance counters:** returns the four counters the CSR block exposes (`csr_*_txcrdt_navail` / `csr_*_txcrdt_avail`).

## Interface
Parameters:
- `CRDTW`, default 16: credit counter width; must equal the CSR init-field width.
- `CNTW`, default 32: performance counter width.

Ports:
- `clk`  in  1  common clock
- `nreset`  in  1  reset; asynchronous, active-low
- `csr_txen`  in  1  TX enable
- `csr_rxen`  in  1  RX enable; rising edge reloads RX credit counters
- `csr_txcrdt_en`  in  1  enable credit-update transmission
- `csr_txcrdt_intrvl`  in  16  update interval in cycles
- `csr_rxcrdt_req_init`  in  16  req FIFO capacity in credits
- `csr_rxcrdt_resp_init`  in  16  resp FIFO capacity in credits
- `tx_req_valid`  in  1  req transaction pending
- `tx_req_crdt`  in  8  credits consumed by pending req
- `tx_req_go`  out  1  req may be sent this cycle
- `tx_resp_valid`  in  1  resp transaction pending
- `tx_resp_crdt`  in  8  credits consumed by pending resp
- `tx_resp_go`  out  1  resp may be sent this cycle
- `rmt_crdt_valid`  in  1  remote credit update received
- `rmt_crdt_req`  in  16  remote cumulative req credit
- `rmt_crdt_resp`  in  16  remote cumulative resp credit
- `rx_req_free`  in  8  req credits freed this cycle
- `rx_resp_free`  in  8  resp credits freed this cycle
- `crdt_upd_valid`  out  1  credit-update message valid
- `crdt_upd_req`  out  16  local cumulative req credit
- `crdt_upd_resp`  out  16  local cumulative resp credit
- `crdt_upd_ready`  in  1  message accepted
- `csr_req_txcrdt_navail`  out  32  performance counter
- `csr_resp_txcrdt_navail`  out  32  performance counter
- `csr_req_txcrdt_avail`  out  32  performance counter
- `csr_resp_txcrdt_avail`  out  32  performance counter

## Operation
All channel logic is instantiated twice, once for req and once for resp; req is described.

- **TX limit and sent count:** `tx_limit` (16b) and `tx_sent` (16b) are both modulo-2^16 cumulative counts.
  - `rmt_crdt_valid` loads `tx_limit <= rmt_crdt_req`.
  - `avail = tx_limit - tx_sent` (mod 2^16).
  - `tx_req_go = csr_txen & tx_req_valid & (avail >= tx_req_crdt)`.
  - On `go`: `tx_sent += tx_req_crdt`.
  - A `tx_req_crdt` of 0 always passes while enabled.
- **RX freed count:** `rx_freed` (16b, cumulative) loads `csr_rxcrdt_req_init` on a `csr_rxen` rising edge; otherwise `rx_freed += rx_req_free` every cycle, mod 2^16.
- **Update FSM:** states IDLE, WAIT, SEND.
  - IDLE → WAIT when `csr_txcrdt_en & csr_txen`, loading the timer with `csr_txcrdt_intrvl`. A loaded value of 0 is treated as 1.
  - WAIT decrements the timer each cycle.
  - At timer==1, WAIT → SEND, snapshotting both `rx_freed` values into `crdt_upd_*`.
  - SEND holds `crdt_upd_valid` with stable data until `crdt_upd_ready`, then goes to WAIT and reloads the timer.
  - Dropping `csr_txcrdt_en` or `csr_txen` returns the FSM to IDLE from WAIT. From SEND it returns to IDLE only after the current message is accepted; a valid is never retracted.
- **Performance counters** are saturating at 2^32-1 and clear only on reset:
  - navail +1 on each cycle with `csr_txen & valid & ~go`.
  - avail +1 on each cycle with `go`.

## Timing
- **Reset values:** all counters, `tx_limit`, `tx_sent`, `rx_freed`, timer and `crdt_upd_*` are 0; FSM is IDLE.
- **Combinational paths:** `go` is combinational from `valid`/`crdt` and registered state; there is no other combinational input-to-output path.
- **Same-cycle update and go:** `go` uses the old `tx_limit`; the new limit is visible next cycle.
- **Same-cycle free and snapshot:** the snapshot excludes same-cycle `rx_*_free`.
- **Same-cycle `csr_rxen` edge and free:** the init load wins and that cycle's free is dropped.
- **Update message latency:** `crdt_upd_valid` first rises N+1 cycles after the enable is seen in IDLE, where N is the interval.
- **Wrap-around:** modulo arithmetic makes counter wrap transparent. A remote limit equal to `tx_sent` means 0 available.
- **Reset mid-message:** asynchronous reset drops `crdt_upd_valid` immediately.

## Structure
- The FSM state encoding constants belong in the shared LUMI package.
- One sub-module is natural: `lumi_crdt_chan`, which covers limit, sent, freed and the two perf counters. It is instantiated once for req and once for resp.
- The top level holds the update FSM and timer.

## Test plan
- **Gate and consume:** after reset, `tx_req_valid=1`, `crdt=4` → `go=0`, navail increments each cycle. Then `rmt_crdt_req=10` → `go=1` next cycle for two sends, then `go=0` with `avail=2`.
- **Wrap:** `tx_sent=0xFFFE`, `rmt_crdt_req=0x0002` → `avail=4`; `crdt=4` sends, then `go=0`.
- **Periodic update:**
  - Setup: `init=0x40`, `csr_rxen` rises, `intrvl=16`, enables high.
  - Check: `crdt_upd_valid` rises 17 cycles after the enable is seen, carrying `req=0x40`.
  - Then: with `rx_req_free=3` for 2 cycles, the next update carries `0x46`.
- **Backpressure:** hold `crdt_upd_ready=0` for 20 cycles → valid and data stay stable; after accept, the timer restarts.
- **Disable mid-send:** drop `csr_txcrdt_en` in SEND → valid held until `ready`, then IDLE with no further messages.
- **Saturation and reset:** preload avail counter to 0xFFFFFFFE, two sends → reads 0xFFFFFFFF. Asserting `nreset` mid-SEND clears all outputs asynchronously.

Source files
------------

// File: rtl/lumi_crdt_pkg.sv
// lumi_crdt_pkg: shared LUMI credit-flow types and constants.
// Revision: 1.0
`default_nettype none

package lumi_crdt_pkg;

  // Width of the per-transaction credit cost and per-cycle freed credits
  localparam int unsigned CRDT_CW = 8;

  typedef enum logic [1:0] {
    CRDT_IDLE = 2'd0,
    CRDT_WAIT = 2'd1,
    CRDT_SEND = 2'd2
  } crdt_state_t;

endpackage

`default_nettype wire

// File: rtl/lumi_crdt_chan.sv
// lumi_crdt_chan: one credit channel (remote limit, sent count, local freed count, perf counters).
// Revision: 1.0
`default_nettype none

module lumi_crdt_chan
  import lumi_crdt_pkg::*;
#(
  parameter int CRDTW = 16,
  parameter int CNTW  = 32
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               txen,
  input  logic               rxen_rise,
  input  logic [CRDTW-1:0]   rx_init,
  input  logic               tx_valid,
  input  logic [CRDT_CW-1:0] tx_crdt,
  output logic               tx_go,
  input  logic               rmt_valid,
  input  logic [CRDTW-1:0]   rmt_crdt,
  input  logic [CRDT_CW-1:0] rx_free,
  output logic [CRDTW-1:0]   rx_freed,
  output logic [CNTW-1:0]    navail_cnt,
  output logic [CNTW-1:0]    avail_cnt
);

  logic [CRDTW-1:0] tx_limit;
  logic [CRDTW-1:0] tx_sent;
  logic [CRDTW-1:0] avail;
  logic [CRDTW-1:0] need;

  // Cumulative counts wrap modulo 2^CRDTW, so the difference is the true headroom
  assign avail = tx_limit - tx_sent;
  assign need  = CRDTW'(tx_crdt);
  assign tx_go = txen & tx_valid & (avail >= need);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_limit <= '0;
      tx_sent  <= '0;
    end else begin
      if (rmt_valid) tx_limit <= rmt_crdt;
      if (tx_go)     tx_sent  <= tx_sent + need;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_freed <= '0;
    end else if (rxen_rise) begin
      rx_freed <= rx_init;
    end else begin
      rx_freed <= rx_freed + CRDTW'(rx_free);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      navail_cnt <= '0;
      avail_cnt  <= '0;
    end else begin
      if (txen && tx_valid && !tx_go && (navail_cnt != {CNTW{1'b1}}))
        navail_cnt <= navail_cnt + CNTW'(1);
      if (tx_go && (avail_cnt != {CNTW{1'b1}}))
        avail_cnt <= avail_cnt + CNTW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/lumi_crdt.sv
// lumi_crdt: LUMI link credit-flow engine; TX gating per channel plus periodic credit-update messages.
// Revision: 1.0
`default_nettype none

module lumi_crdt
  import lumi_crdt_pkg::*;
#(
  parameter int CRDTW = 16,
  parameter int CNTW  = 32
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               csr_txen,
  input  logic               csr_rxen,
  input  logic               csr_txcrdt_en,
  input  logic [15:0]        csr_txcrdt_intrvl,
  input  logic [CRDTW-1:0]   csr_rxcrdt_req_init,
  input  logic [CRDTW-1:0]   csr_rxcrdt_resp_init,
  input  logic               tx_req_valid,
  input  logic [CRDT_CW-1:0] tx_req_crdt,
  output logic               tx_req_go,
  input  logic               tx_resp_valid,
  input  logic [CRDT_CW-1:0] tx_resp_crdt,
  output logic               tx_resp_go,
  input  logic               rmt_crdt_valid,
  input  logic [CRDTW-1:0]   rmt_crdt_req,
  input  logic [CRDTW-1:0]   rmt_crdt_resp,
  input  logic [CRDT_CW-1:0] rx_req_free,
  input  logic [CRDT_CW-1:0] rx_resp_free,
  output logic               crdt_upd_valid,
  output logic [CRDTW-1:0]   crdt_upd_req,
  output logic [CRDTW-1:0]   crdt_upd_resp,
  input  logic               crdt_upd_ready,
  output logic [CNTW-1:0]    csr_req_txcrdt_navail,
  output logic [CNTW-1:0]    csr_resp_txcrdt_navail,
  output logic [CNTW-1:0]    csr_req_txcrdt_avail,
  output logic [CNTW-1:0]    csr_resp_txcrdt_avail
);

  crdt_state_t      state;
  logic [15:0]      timer;
  logic [15:0]      intrvl_eff;
  logic             upd_en;
  logic             rxen_q;
  logic             rxen_rise;
  logic [CRDTW-1:0] req_freed;
  logic [CRDTW-1:0] resp_freed;

  assign rxen_rise  = csr_rxen & ~rxen_q;
  assign upd_en     = csr_txcrdt_en & csr_txen;
  assign intrvl_eff = (csr_txcrdt_intrvl == 16'd0) ? 16'd1 : csr_txcrdt_intrvl;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) rxen_q <= 1'b0;
    else         rxen_q <= csr_rxen;
  end

  lumi_crdt_chan #(.CRDTW(CRDTW), .CNTW(CNTW)) u_req (
    .clk        (clk),
    .nreset     (nreset),
    .txen       (csr_txen),
    .rxen_rise  (rxen_rise),
    .rx_init    (csr_rxcrdt_req_init),
    .tx_valid   (tx_req_valid),
    .tx_crdt    (tx_req_crdt),
    .tx_go      (tx_req_go),
    .rmt_valid  (rmt_crdt_valid),
    .rmt_crdt   (rmt_crdt_req),
    .rx_free    (rx_req_free),
    .rx_freed   (req_freed),
    .navail_cnt (csr_req_txcrdt_navail),
    .avail_cnt  (csr_req_txcrdt_avail)
  );

  lumi_crdt_chan #(.CRDTW(CRDTW), .CNTW(CNTW)) u_resp (
    .clk        (clk),
    .nreset     (nreset),
    .txen       (csr_txen),
    .rxen_rise  (rxen_rise),
    .rx_init    (csr_rxcrdt_resp_init),
    .tx_valid   (tx_resp_valid),
    .tx_crdt    (tx_resp_crdt),
    .tx_go      (tx_resp_go),
    .rmt_valid  (rmt_crdt_valid),
    .rmt_crdt   (rmt_crdt_resp),
    .rx_free    (rx_resp_free),
    .rx_freed   (resp_freed),
    .navail_cnt (csr_resp_txcrdt_navail),
    .avail_cnt  (csr_resp_txcrdt_avail)
  );

  // A pending message is always completed before the FSM honours a disable
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state          <= CRDT_IDLE;
      timer          <= '0;
      crdt_upd_valid <= 1'b0;
      crdt_upd_req   <= '0;
      crdt_upd_resp  <= '0;
    end else begin
      case (state)
        CRDT_IDLE: begin
          if (upd_en) begin
            state <= CRDT_WAIT;
            timer <= intrvl_eff;
          end
        end
        CRDT_WAIT: begin
          if (!upd_en) begin
            state <= CRDT_IDLE;
          end else begin
            timer <= timer - 16'd1;
            if (timer == 16'd1) begin
              state          <= CRDT_SEND;
              crdt_upd_valid <= 1'b1;
              crdt_upd_req   <= req_freed;
              crdt_upd_resp  <= resp_freed;
            end
          end
        end
        CRDT_SEND: begin
          if (crdt_upd_ready) begin
            crdt_upd_valid <= 1'b0;
            if (upd_en) begin
              state <= CRDT_WAIT;
              timer <= intrvl_eff;
            end else begin
              state <= CRDT_IDLE;
            end
          end
        end
        default: begin
          state          <= CRDT_IDLE;
          crdt_upd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
